// File: rtl/dfp_compare96_sched_pkg.sv
// Shared types, condition-code bit positions, DPD helpers and reference constants
// for the shared DFP96 compare scheduler.
package dfp_compare96_sched_pkg;

  typedef logic [95:0] dfp96_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RESP = 2'd2
  } sched_state_e;

  // Bit 10 of the condition vector is reserved and always reads 0.
  localparam int CC_EQ  = 0;
  localparam int CC_LT  = 1;
  localparam int CC_LE  = 2;
  localparam int CC_LTU = 3;
  localparam int CC_UN  = 4;
  localparam int CC_NE  = 5;
  localparam int CC_GE  = 6;
  localparam int CC_GT  = 7;
  localparam int CC_GEU = 8;
  localparam int CC_OR  = 9;
  localparam int CC_LT2 = 11;

  // Layout: sign[95], combination G[94:90], exponent continuation[89:80], 8 declets[79:0].
  localparam dfp96_t DFP96_ZERO  = {1'b0, 5'b01000, 10'h217, 80'h0};
  localparam dfp96_t DFP96_NZERO = {1'b1, 5'b01000, 10'h217, 80'h0};
  localparam dfp96_t DFP96_ONE   = {1'b0, 5'b01000, 10'h217, 80'h1};
  localparam dfp96_t DFP96_TWO   = {1'b0, 5'b01000, 10'h217, 80'h2};
  localparam dfp96_t DFP96_QNAN  = {1'b0, 5'b11111, 90'h0};

  // Ordering key: class (0 zero, 1 finite, 2 inf), adjusted exponent, left-aligned BCD mantissa.
  typedef struct packed {
    logic        nan;
    logic        neg;
    logic [1:0]  cls;
    logic [12:0] aexp;
    logic [99:0] mant;
  } dfp_key_t;

  function automatic logic [11:0] dpd_decode(input logic [9:0] d);
    logic [11:0] r;
    if (!d[3]) begin
      r = {1'b0, d[9:7], 1'b0, d[6:4], 1'b0, d[2:0]};
    end else begin
      case (d[2:1])
        2'b00:   r = {1'b0, d[9:7], 1'b0, d[6:4], 3'b100, d[0]};
        2'b01:   r = {1'b0, d[9:7], 3'b100, d[4], 1'b0, d[6:5], d[0]};
        2'b10:   r = {3'b100, d[7], 1'b0, d[6:4], 1'b0, d[9:8], d[0]};
        default: begin
          case (d[6:5])
            2'b00:   r = {3'b100, d[7], 3'b100, d[4], 1'b0, d[9:8], d[0]};
            2'b01:   r = {3'b100, d[7], 1'b0, d[9:8], d[4], 3'b100, d[0]};
            2'b10:   r = {1'b0, d[9:7], 3'b100, d[4], 3'b100, d[0]};
            default: r = {3'b100, d[7], 3'b100, d[4], 3'b100, d[0]};
          endcase
        end
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/dfp_compare96_sched_arb.sv
// Round-robin arbiter: grants the first requester at or above ptr, wrapping at NREQ-1.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_grant_idx,
  output logic            o_any
);

  logic [IDW:0] w_cand;
  logic         w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      // Explicit wrap keeps ids below NREQ when NREQ is not a power of two.
      w_cand = {1'b0, i_ptr} + (IDW+1)'(i);
      if (w_cand >= (IDW+1)'(NREQ)) w_cand = w_cand - (IDW+1)'(NREQ);
      if (!w_found && i_req[w_cand[IDW-1:0]]) begin
        w_found                   = 1'b1;
        o_grant[w_cand[IDW-1:0]]  = 1'b1;
        o_grant_idx               = w_cand[IDW-1:0];
      end
    end
  end

  assign o_any = w_found;

endmodule

// File: rtl/dfp_compare96_sched_cmp.sv
// Combinational DFP96 (DPD) compare producing the 12-bit condition vector.
module dfp96_compare
  import dfp_compare96_sched_pkg::*;
(
  input  dfp96_t      i_a,
  input  dfp96_t      i_b,
  output logic [11:0] o_cc
);

  // Normalising both mantissas to a leading non-zero digit makes the ordering a plain
  // lexicographic compare of {class, adjusted exponent, mantissa}.
  function automatic dfp_key_t make_key(input dfp96_t x);
    dfp_key_t    k;
    logic [11:0] bexp;
    logic [3:0]  msd;
    logic [99:0] bcd;
    int          lz;
    logic        found;
    k     = '0;
    bexp  = '0;
    msd   = '0;
    bcd   = '0;
    lz    = 0;
    found = 1'b0;
    if (x[94:91] == 4'b1111) begin
      k.nan = x[90];
      k.cls = x[90] ? 2'd0 : 2'd2;
      k.neg = x[90] ? 1'b0 : x[95];
    end else begin
      if (x[94:93] != 2'b11) begin
        bexp = {x[94:93], x[89:80]};
        msd  = {1'b0, x[92:90]};
      end else begin
        bexp = {x[92:91], x[89:80]};
        msd  = {3'b100, x[90]};
      end
      for (int i = 0; i < 8; i++) bcd[i*12 +: 12] = dpd_decode(x[i*10 +: 10]);
      bcd[99:96] = msd;
      for (int i = 24; i >= 0; i--) begin
        if (!found) begin
          if (bcd[i*4 +: 4] != 4'd0) found = 1'b1;
          else lz = lz + 1;
        end
      end
      if (found) begin
        k.cls  = 2'd1;
        k.neg  = x[95];
        k.aexp = 13'(bexp) + 13'(24 - lz);
        k.mant = bcd << (4 * lz);
      end
    end
    return k;
  endfunction

  dfp_key_t       w_ka, w_kb;
  logic [114:0]   w_mag_a, w_mag_b;
  logic           w_un, w_eq, w_lt, w_gt;

  assign w_ka    = make_key(i_a);
  assign w_kb    = make_key(i_b);
  assign w_mag_a = {w_ka.cls, w_ka.aexp, w_ka.mant};
  assign w_mag_b = {w_kb.cls, w_kb.aexp, w_kb.mant};
  assign w_un    = w_ka.nan | w_kb.nan;
  assign w_eq    = !w_un && (w_mag_a == w_mag_b) && (w_ka.neg == w_kb.neg);
  assign w_gt    = !w_un && !w_eq && !w_lt;

  always_comb begin
    w_lt = 1'b0;
    if (!w_un) begin
      if (w_ka.neg != w_kb.neg) w_lt = w_ka.neg;
      else if (w_ka.neg)        w_lt = (w_mag_a > w_mag_b);
      else                      w_lt = (w_mag_a < w_mag_b);
    end
  end

  always_comb begin
    o_cc         = '0;
    o_cc[CC_EQ]  = w_eq;
    o_cc[CC_LT]  = w_lt;
    o_cc[CC_LE]  = w_lt | w_eq;
    o_cc[CC_LTU] = w_lt | w_un;
    o_cc[CC_UN]  = w_un;
    o_cc[CC_NE]  = !w_eq;
    o_cc[CC_GE]  = w_gt | w_eq;
    o_cc[CC_GT]  = w_gt;
    o_cc[CC_GEU] = w_gt | w_eq | w_un;
    o_cc[CC_OR]  = !w_un;
    o_cc[CC_LT2] = w_lt;
  end

endmodule

// File: rtl/dfp_compare96_sched.sv
// Round-robin scheduler sharing one DFP96 compare datapath among NREQ requesters.
// Handshake: a request transfers when req_valid[i] & req_ready[i] at a rising edge; a response transfers when rsp_valid & rsp_ready at a rising edge.
module dfp_compare96_sched
  import dfp_compare96_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*96-1:0] req_a,
  input  logic [NREQ*96-1:0] req_b,
  input  logic [NREQ*4-1:0]  req_op,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [TAGW-1:0]    rsp_tag,
  output logic [11:0]        rsp_cc,
  output logic               rsp_res,
  output logic               rsp_nanx,
  output logic               rsp_badop,
  output sched_state_e       dbg_state
);

  sched_state_e    r_state, w_next;
  logic [IDW-1:0]  r_ptr, r_id, w_gidx, w_ptr_nxt;
  dfp96_t          r_a, r_b;
  logic [3:0]      r_op;
  logic [TAGW-1:0] r_tag;
  logic [NREQ-1:0] w_grant;
  logic            w_any, w_take;
  logic [11:0]     w_cc;
  logic [15:0]     w_cc_ext;
  logic            w_badop, w_res, w_nanx;
  logic [IDW-1:0]  r_rsp_id;
  logic [TAGW-1:0] r_rsp_tag;
  logic [11:0]     r_rsp_cc;
  logic            r_rsp_res, r_rsp_nanx, r_rsp_badop;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req       (req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx),
    .o_any       (w_any)
  );

  dfp96_compare u_cmp (
    .i_a  (r_a),
    .i_b  (r_b),
    .o_cc (w_cc)
  );

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_take = 1'b1;
          w_next = ST_CMP;
        end
      end
      ST_CMP:  w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_ptr_nxt = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
  // Gating with rst keeps every output at zero while reset is held.
  assign req_ready = (r_state == ST_IDLE && !rst) ? w_grant : '0;

  assign w_cc_ext = {4'b0000, w_cc};
  assign w_badop  = (r_op > 4'd11);
  assign w_res    = w_badop ? 1'b0 : w_cc_ext[r_op];
  assign w_nanx   = !w_badop && w_cc[CC_UN] && (r_op != 4'd4) && (r_op != 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_tag       <= '0;
      r_rsp_id    <= '0;
      r_rsp_tag   <= '0;
      r_rsp_cc    <= '0;
      r_rsp_res   <= 1'b0;
      r_rsp_nanx  <= 1'b0;
      r_rsp_badop <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_a   <= req_a[w_gidx*96 +: 96];
        r_b   <= req_b[w_gidx*96 +: 96];
        r_op  <= req_op[w_gidx*4 +: 4];
        r_tag <= req_tag[w_gidx*TAGW +: TAGW];
        r_id  <= w_gidx;
        r_ptr <= w_ptr_nxt;
      end
      if (r_state == ST_CMP) begin
        r_rsp_id    <= r_id;
        r_rsp_tag   <= r_tag;
        r_rsp_cc    <= w_cc;
        r_rsp_res   <= w_res;
        r_rsp_nanx  <= w_nanx;
        r_rsp_badop <= w_badop;
      end
    end
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_tag   = r_rsp_tag;
  assign rsp_cc    = r_rsp_cc;
  assign rsp_res   = r_rsp_res;
  assign rsp_nanx  = r_rsp_nanx;
  assign rsp_badop = r_rsp_badop;
  assign dbg_state = r_state;

endmodule

// File: doc/dfp_compare96_sched.md
Name: dfp_compare96_sched

Overview:
Shares one combinational DFP96 compare datapath (12-bit condition vector) among NREQ requesters. Each request carries two DFP96 operands, a predicate select and a tag. A round-robin arbiter grants one request at a time. Operands are registered before the comparator, and the selected predicate is returned on a single tagged response channel. Sits between the issue/reservation logic and the shared DFP compare resource in the decimal FPU.

Parameters:
NREQ, 4, number of requesters (2..8)
TAGW, 4, width of per-request tag returned unchanged
IDW, $clog2(NREQ), width of requester id on response

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  NREQ  request present, one bit per requester
req_ready  output  NREQ  request accepted this cycle (one-hot or zero)
req_a  input  NREQ*96  operand A per requester (DFP96)
req_b  input  NREQ*96  operand B per requester (DFP96)
req_op  input  NREQ*4  predicate select per requester
req_tag  input  NREQ*TAGW  tag per requester
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_id  output  IDW  index of originating requester
rsp_tag  output  TAGW  tag of the request
rsp_cc  output  12  full condition vector from the comparator
rsp_res  output  1  cc bit selected by op
rsp_nanx  output  1  invalid-operation flag
rsp_badop  output  1  op outside 0..11

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, rst.
- Reset values: all outputs 0; state IDLE; round-robin pointer 0.
- FSM has three states: IDLE, CMP, RESP. One transaction is in flight at most.
- IDLE:
  - If any req_valid is high, grant the first set bit searching from the pointer upward with wrap.
  - Assert req_ready for the granted requester only, combinationally, in the same cycle.
  - Latch a, b, op, tag and id; go to CMP.
  - Pointer becomes (grant+1) mod NREQ.
  - With no request, req_ready stays 0 and the pointer is unchanged.
- CMP:
  - Comparator evaluates the latched operands.
  - At the clock edge, capture rsp_cc, rsp_res, rsp_nanx and rsp_badop; go to RESP.
- RESP:
  - rsp_valid=1; all outputs are held stable.
  - When rsp_ready=1, go to IDLE with rsp_valid=0 at the next edge.
  - No new grant is issued in the cycle the response retires.
- Latency: an accept at edge N gives rsp_valid at edge N+2. Minimum issue interval is 3 cycles.
- req_ready is 0 outside IDLE. A requester holds valid and data until it sees ready.
- rsp_res = rsp_cc[op] for op 0..11. For op 12..15: rsp_res=0, rsp_badop=1, rsp_cc still reported.
- rsp_nanx = cc[4] (unordered) AND op not in {4, 9}. This covers the ordered/unordered predicates. rsp_nanx is 0 when rsp_badop=1.
- A requester dropping req_valid before grant is legal; it is not granted.
- With NREQ not a power of two, the pointer wraps from NREQ-1 to 0. Ids NREQ..2^IDW-1 are never produced.
- rst asserted mid-transaction: the transaction is dropped, no response is produced, and all state returns to reset values immediately.

Decomposition:
- DFPPkg (shared package) holds:
  - the DFP96 type, already defined there;
  - new localparams for cc bit indices (CC_EQ=0, CC_LT=1, CC_LE=2, CC_LTU=3, CC_UN=4, CC_NE=5, CC_GE=6, CC_GT=7, CC_GEU=8, CC_OR=9, CC_LT2=11);
  - an enum for the FSM states;
  - constants DFP96_ZERO, DFP96_NZERO, DFP96_ONE, DFP96_TWO and DFP96_QNAN for benches.
- Sub-module rr_arbiter (parameter NREQ): inputs req and ptr, outputs one-hot grant and its index. It is reusable by the other DFP shared-unit schedulers.
- The existing DFP96 compare module is instantiated once on the operand registers.

Test Plan:
- Basic compare: requester 2, a=DFP96_ONE, b=DFP96_TWO, op=1, tag=5 -> req_ready[2] in the accept cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_tag=5, rsp_res=1, rsp_cc[0]=0, rsp_nanx=0.
- Signed zeros: a=+0, b=-0, op=0 -> rsp_res=1 (eq); op=1 -> rsp_res=0.
- NaN operand: a=DFP96_QNAN, b=DFP96_ONE:
  - op=4 -> rsp_res=1, rsp_nanx=0;
  - op=2 -> rsp_res=0, rsp_nanx=1;
  - op=13 -> rsp_badop=1, rsp_res=0, rsp_nanx=0.
- Fairness: all 4 requesters hold valid continuously -> grant order 0,1,2,3,0,… with rsp_id matching. Each response holds 3 cycles apart when rsp_ready=1.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and all payload stay stable, req_ready stays 0; release -> next grant is issued one cycle after retirement.
- Reset mid-op: assert rst during CMP -> no response appears; outputs 0 immediately; after release, requester 0 is granted first.
